// File: rtl/luna_cpu_pkg.sv
// rtl/luna_cpu_pkg.sv - shared state encoding and instruction field positions
// Contents:
//   seq_state_t   - fetch sequencer state encoding
//   INSTR_*_BIT   - instruction type and a-bit positions
//   DEST_*_BIT    - dest field bit indices {A,D,M} = bits 5:3
//   JMP_*_BIT     - jump field bit indices {lt,eq,gt} = bits 2:0
//   jump_bits()   - extracts the jump field from an instruction word
package luna_cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MREAD  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_MWRITE = 3'd5,
        ST_ERROR  = 3'd6
    } seq_state_t;

    localparam int INSTR_TYPE_BIT = 15;
    localparam int INSTR_ABIT     = 12;

    localparam int DEST_A_BIT = 5;
    localparam int DEST_D_BIT = 4;
    localparam int DEST_M_BIT = 3;

    localparam int JMP_LT_BIT = 2;
    localparam int JMP_EQ_BIT = 1;
    localparam int JMP_GT_BIT = 0;

    function automatic logic [2:0] jump_bits(input logic [15:0] instr);
        return instr[JMP_LT_BIT:JMP_GT_BIT];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction and data memory handshake bundle
// Signals:
//   imem_req/imem_addr -> memory, imem_ack/imem_rdata <- memory
//   dmem_req/dmem_we/dmem_addr/dmem_wdata -> memory, dmem_ack/dmem_rdata <- memory
// Modports: master (sequencer side), slave (memory side)
interface fetch_sequencer_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/jump_cond.sv
// rtl/jump_cond.sv - combinational jump condition evaluation
// Ports:
//   alu_result in 16 - ALU output for the current instruction
//   jump       in 3  - jump field {lt,eq,gt}
//   taken      out 1 - jump condition satisfied
module jump_cond
    import luna_cpu_pkg::*;
(
    input  logic [15:0] alu_result,
    input  logic [2:0]  jump,
    output logic        taken
);

    logic lt;
    logic eq;
    logic gt;

    assign lt    = alu_result[15];
    assign eq    = (alu_result == 16'h0000);
    assign gt    = !lt && !eq;
    assign taken = (jump[JMP_LT_BIT] & lt) |
                   (jump[JMP_EQ_BIT] & eq) |
                   (jump[JMP_GT_BIT] & gt);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / memory sequencing control unit
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   bus (master)        - imem/dmem request/ack handshakes
//   cu_instr   out 16   - latched instruction word
//   reg_m_q    out 16   - latched M operand
//   reg_a_q    in  16   - current A register
//   alu_result in  16   - combinational ALU output
//   reg_a_en, reg_d_en out - one-cycle A/D write strobes
//   a_sel      out 1    - 0: A <= cu_instr, 1: A <= alu_result
//   pc_q       out 16   - program counter
//   halt       in  1    - block new fetches
//   retire     out 1    - pulse per completed instruction
//   bus_err    out 1    - sticky memory ack timeout
module fetch_sequencer
    import luna_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus,
    output logic [15:0]       cu_instr,
    output logic [15:0]       reg_m_q,
    input  logic [15:0]       reg_a_q,
    input  logic [15:0]       alu_result,
    output logic              reg_a_en,
    output logic              reg_d_en,
    output logic              a_sel,
    output logic [15:0]       pc_q,
    input  logic              halt,
    output logic              retire,
    output logic              bus_err
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    // Last waiting cycle: one more cycle without ack reaches ACK_TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    seq_state_t        state_q, state_d;
    logic [15:0]       pc_d;
    logic [15:0]       cu_instr_q, cu_instr_d;
    logic [15:0]       reg_m_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              taken_q, taken_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              imem_req;
    logic              dmem_req;
    logic              dmem_we;
    logic              taken_now;
    logic              wait_expired;
    logic [15:0]       pc_inc;

    jump_cond u_jump_cond (
        .alu_result (alu_result),
        .jump       (jump_bits(cu_instr_q)),
        .taken      (taken_now)
    );

    assign pc_inc       = pc_q + 16'd1;
    assign wait_expired = (wait_q == WAIT_LAST);

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;

    assign cu_instr = cu_instr_q;
    assign bus_err  = (state_q == ST_ERROR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            cu_instr_q <= 16'h0000;
            reg_m_q    <= 16'h0000;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            taken_q    <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cu_instr_q <= cu_instr_d;
            reg_m_q    <= reg_m_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            taken_q    <= taken_d;
            wait_q     <= wait_d;
        end
    end

    // The wait counter only advances while a request is outstanding, so it is
    // zero whenever a request state is entered.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cu_instr_d = cu_instr_q;
        reg_m_d    = reg_m_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        taken_d    = taken_q;
        wait_d     = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_a_en   = 1'b0;
        reg_d_en   = 1'b0;
        a_sel      = 1'b0;
        retire     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                // Halt gates the request itself, so acks seen while halted
                // are never consumed.
                if (!halt) begin
                    imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        cu_instr_d = bus.imem_rdata;
                        state_d    = ST_DECODE;
                    end else if (wait_expired) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end

            ST_DECODE: begin
                if (!cu_instr_q[INSTR_TYPE_BIT]) begin
                    reg_a_en = 1'b1;
                    pc_d     = pc_inc;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    // A is captured here so the memory address and jump
                    // target ignore this instruction's own A write.
                    addr_d  = reg_a_q;
                    state_d = cu_instr_q[INSTR_ABIT] ? ST_MREAD : ST_EXEC;
                end
            end

            ST_MREAD: begin
                dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    reg_m_d = bus.dmem_rdata;
                    state_d = ST_EXEC;
                end else if (wait_expired) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_EXEC: begin
                reg_a_en = cu_instr_q[DEST_A_BIT];
                reg_d_en = cu_instr_q[DEST_D_BIT];
                a_sel    = 1'b1;
                wdata_d  = alu_result;
                // ALU output may change once A/D are written, so keep the
                // jump decision for the MWRITE completion.
                taken_d  = taken_now;
                if (cu_instr_q[DEST_M_BIT]) begin
                    state_d = ST_MWRITE;
                end else begin
                    pc_d    = taken_now ? addr_q : pc_inc;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_MWRITE: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (bus.dmem_ack) begin
                    pc_d    = taken_q ? addr_q : pc_inc;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (wait_expired) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_ERROR: state_d = ST_ERROR;

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [15:0] reg_a_q;
    logic [15:0] alu_result;
    logic [15:0] cu_instr;
    logic [15:0] reg_m_q;
    logic        reg_a_en;
    logic        reg_d_en;
    logic        a_sel;
    logic [15:0] pc_q;
    logic        retire;
    logic        bus_err;

    logic        imem_auto;
    logic        imem_force;
    logic        dmem_auto;
    logic [15:0] imem_word;
    logic [15:0] dmem_word;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer_if bus();

    assign bus.imem_ack   = imem_force | (imem_auto & bus.imem_req);
    assign bus.imem_rdata = imem_word;
    assign bus.dmem_ack   = dmem_auto & bus.dmem_req;
    assign bus.dmem_rdata = dmem_word;

    fetch_sequencer #(
        .RESET_PC    (16'h0000),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cu_instr   (cu_instr),
        .reg_m_q    (reg_m_q),
        .reg_a_q    (reg_a_q),
        .alu_result (alu_result),
        .reg_a_en   (reg_a_en),
        .reg_d_en   (reg_d_en),
        .a_sel      (a_sel),
        .pc_q       (pc_q),
        .halt       (halt),
        .retire     (retire),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          r_cycles, r_aen, r_den, r_rd, r_wr;
    logic        r_asel;
    logic [15:0] r_rd_addr, r_wr_addr, r_wr_data, r_faddr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from a halted FETCH and leaves the DUT halted in
    // FETCH afterwards, recording strobes and memory traffic on the way.
    task automatic run_instr(input logic [15:0] instr);
        imem_word = instr;
        halt      = 1'b0;
        #1;
        r_cycles = 0; r_aen = 0; r_den = 0; r_rd = 0; r_wr = 0;
        r_asel = 1'bx; r_rd_addr = 'x; r_wr_addr = 'x; r_wr_data = 'x;
        r_faddr = bus.imem_addr;
        for (int c = 1; c <= 20; c++) begin
            if (reg_a_en) begin r_aen++; r_asel = a_sel; end
            if (reg_d_en) r_den++;
            if (bus.dmem_req && bus.dmem_ack) begin
                if (bus.dmem_we) begin
                    r_wr++; r_wr_addr = bus.dmem_addr; r_wr_data = bus.dmem_wdata;
                end else begin
                    r_rd++; r_rd_addr = bus.dmem_addr;
                end
            end
            if (retire) begin
                r_cycles = c;
                halt = 1'b1;
                tick();
                break;
            end
            tick();
        end
        halt = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; halt = 1'b1; imem_auto = 1'b1; imem_force = 1'b0; dmem_auto = 1'b1;
        imem_word = 16'h0000; dmem_word = 16'h0000; reg_a_q = 16'h0000; alu_result = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pc_q !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc_q); end
        n_checks++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got imem %b dmem %b expected 0 0", bus.imem_req, bus.dmem_req); end
        n_checks++; if ({retire, bus_err, reg_a_en, reg_d_en} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {retire, bus_err, reg_a_en, reg_d_en}); end
        n_checks++; if (cu_instr !== 16'h0000 || reg_m_q !== 16'h0000 || bus.dmem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_regs: got %h %h %h expected 0000 0000 0000", cu_instr, reg_m_q, bus.dmem_wdata); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b expected 0", bus.imem_req); end
        tick();
        n_checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL halt_fetch: got req %b addr %h expected 0 0000", bus.imem_req, bus.imem_addr); end
        imem_force = 1'b1; imem_word = 16'h1234;
        tick(); tick();
        imem_force = 1'b0;
        n_checks++; if (cu_instr !== 16'h0000 || retire !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got instr %h retire %b expected 0000 0", cu_instr, retire); end
    endtask

    task automatic test_a_instr();
        run_instr(16'h0003);
        n_checks++; if (r_cycles !== 2) begin n_fail++; $display("FAIL a_latency: got %0d expected 2", r_cycles); end
        n_checks++; if (r_aen !== 1 || r_asel !== 1'b0 || r_den !== 0) begin n_fail++; $display("FAIL a_strobes: got aen %0d asel %b den %0d expected 1 0 0", r_aen, r_asel, r_den); end
        n_checks++; if (r_rd !== 0 || r_wr !== 0) begin n_fail++; $display("FAIL a_dmem: got rd %0d wr %0d expected 0 0", r_rd, r_wr); end
        n_checks++; if (cu_instr !== 16'h0003 || r_faddr !== 16'h0000 || pc_q !== 16'h0001) begin n_fail++; $display("FAIL a_pc: got instr %h faddr %h pc %h expected 0003 0000 0001", cu_instr, r_faddr, pc_q); end
    endtask

    task automatic test_c_alu();
        reg_a_q = 16'h0002; alu_result = 16'h0005;
        run_instr(16'b1110_000010_110_000);
        n_checks++; if (r_cycles !== 3) begin n_fail++; $display("FAIL c_latency: got %0d expected 3", r_cycles); end
        n_checks++; if (r_aen !== 1 || r_asel !== 1'b1 || r_den !== 1) begin n_fail++; $display("FAIL c_strobes: got aen %0d asel %b den %0d expected 1 1 1", r_aen, r_asel, r_den); end
        n_checks++; if (r_rd !== 0 || r_wr !== 0 || pc_q !== 16'h0002) begin n_fail++; $display("FAIL c_pc: got rd %0d wr %0d pc %h expected 0 0 0002", r_rd, r_wr, pc_q); end
    endtask

    task automatic test_mem_rw();
        reg_a_q = 16'h0004; dmem_word = 16'h0007; alu_result = 16'h0009;
        run_instr(16'b1111_000010_001_000);
        n_checks++; if (r_cycles !== 5) begin n_fail++; $display("FAIL m_latency: got %0d expected 5", r_cycles); end
        n_checks++; if (r_rd !== 1 || r_rd_addr !== 16'h0004 || reg_m_q !== 16'h0007) begin n_fail++; $display("FAIL m_read: got n %0d addr %h m %h expected 1 0004 0007", r_rd, r_rd_addr, reg_m_q); end
        n_checks++; if (r_wr !== 1 || r_wr_addr !== 16'h0004 || r_wr_data !== 16'h0009) begin n_fail++; $display("FAIL m_write: got n %0d addr %h data %h expected 1 0004 0009", r_wr, r_wr_addr, r_wr_data); end
        n_checks++; if (r_aen !== 0 || r_den !== 0 || pc_q !== 16'h0003) begin n_fail++; $display("FAIL m_pc: got aen %0d den %0d pc %h expected 0 0 0003", r_aen, r_den, pc_q); end
    endtask

    task automatic test_jump();
        reg_a_q = 16'h0020; alu_result = 16'hFFFB;
        run_instr(16'b1110_000000_000_100);
        n_checks++; if (r_cycles !== 3 || pc_q !== 16'h0020) begin n_fail++; $display("FAIL jlt_taken: got cyc %0d pc %h expected 3 0020", r_cycles, pc_q); end
        alu_result = 16'h0002;
        run_instr(16'b1110_000000_000_100);
        n_checks++; if (pc_q !== 16'h0021) begin n_fail++; $display("FAIL jlt_not_taken: got %h expected 0021", pc_q); end
        reg_a_q = 16'h0040; alu_result = 16'h0000;
        run_instr(16'b1110_000000_000_010);
        n_checks++; if (pc_q !== 16'h0040) begin n_fail++; $display("FAIL jeq_taken: got %h expected 0040", pc_q); end
        run_instr(16'b1110_000000_000_001);
        n_checks++; if (pc_q !== 16'h0041) begin n_fail++; $display("FAIL jgt_zero: got %h expected 0041", pc_q); end
        reg_a_q = 16'h0100; alu_result = 16'h0003;
        run_instr(16'b1110_000000_001_111);
        n_checks++; if (r_cycles !== 4 || r_wr !== 1 || r_wr_addr !== 16'h0100 || r_wr_data !== 16'h0003) begin n_fail++; $display("FAIL jmp_mwrite: got cyc %0d n %0d addr %h data %h expected 4 1 0100 0003", r_cycles, r_wr, r_wr_addr, r_wr_data); end
        n_checks++; if (pc_q !== 16'h0100) begin n_fail++; $display("FAIL jmp_mwrite_pc: got %h expected 0100", pc_q); end
    endtask

    task automatic test_wrap();
        reg_a_q = 16'hFFFF; alu_result = 16'h0001;
        run_instr(16'b1110_000000_000_111);
        n_checks++; if (pc_q !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_jump: got %h expected ffff", pc_q); end
        run_instr(16'h0005);
        n_checks++; if (r_faddr !== 16'hFFFF || pc_q !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got faddr %h pc %h expected ffff 0000", r_faddr, pc_q); end
    endtask

    task automatic test_back_to_back();
        int n_ret;
        int n_req;
        n_ret = 0; n_req = 0;
        imem_word = 16'h0001; halt = 1'b0;
        #1;
        for (int c = 1; c <= 6; c++) begin
            if (retire) n_ret++;
            if (bus.imem_req) n_req++;
            if (c == 6) halt = 1'b1;
            tick();
        end
        n_checks++; if (n_ret !== 3 || n_req !== 3) begin n_fail++; $display("FAIL b2b_count: got retire %0d req %0d expected 3 3", n_ret, n_req); end
        n_checks++; if (pc_q !== 16'h0003 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_pc: got pc %h req %b expected 0003 0", pc_q, bus.imem_req); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        imem_auto = 1'b0; halt = 1'b0;
        #1;
        for (int c = 0; c < 400 && bus.imem_req; c++) begin
            req_cycles++;
            if (req_cycles == 255) begin
                n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", bus_err); end
            end
            tick();
        end
        n_checks++; if (req_cycles !== 255) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 255", req_cycles); end
        n_checks++; if (bus_err !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_err: got err %b req %b expected 1 0", bus_err, bus.imem_req); end
        imem_auto = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || retire !== 1'b0) begin n_fail++; $display("FAIL error_sticky: got err %b ireq %b dreq %b ret %b expected 1 0 0 0", bus_err, bus.imem_req, bus.dmem_req, retire); end
        halt = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++; if (bus_err !== 1'b0 || pc_q !== 16'h0000) begin n_fail++; $display("FAIL error_reset: got err %b pc %h expected 0 0000", bus_err, pc_q); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_mread();
        dmem_auto = 1'b0; reg_a_q = 16'h0004; imem_word = 16'b1111_000010_001_000; halt = 1'b0;
        #1;
        tick();
        halt = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 16'h0004) begin n_fail++; $display("FAIL mread_wait: got req %b we %b addr %h expected 1 0 0004", bus.dmem_req, bus.dmem_we, bus.dmem_addr); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.dmem_req !== 1'b0 || cu_instr !== 16'h0000 || pc_q !== 16'h0000) begin n_fail++; $display("FAIL mid_reset: got dreq %b instr %h pc %h expected 0 0000 0000", bus.dmem_req, cu_instr, pc_q); end
        #1;
        rst = 1'b1;
        dmem_auto = 1'b1;
        tick();
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_after_reset: got %b expected 0", bus.imem_req); end
        halt = 1'b0;
        #1;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_fetch: got req %b addr %h expected 1 0000", bus.imem_req, bus.imem_addr); end
        halt = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_a_instr();
        test_c_alu();
        test_mem_rw();
        test_jump();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_mid_mread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be: RESET_PC, 16'h0000, first fetch address; ACK_TIMEOUT, 255, maximum wait cycles for any memory ack.
REQ-002 Clock and reset SHALL be: clk  in  1  single clock, all logic on rising edge; rst  in  1  asynchronous, active-low reset.
REQ-003 Instruction port SHALL be: imem_req  out  1  fetch request; imem_addr  out  16  fetch address (=pc_q); imem_ack  in  1  fetch done; imem_rdata  in  16  instruction word.
REQ-004 Data port SHALL be: dmem_req  out  1; dmem_we  out  1  1=write; dmem_addr  out  16; dmem_wdata  out  16; dmem_ack  in  1; dmem_rdata  in  16.
REQ-005 Datapath side SHALL be: cu_instr  out  16  latched instruction; reg_m_q  out  16  latched M operand; reg_a_q  in  16  current A; alu_result  in  16  combinational ALU output; reg_a_en, reg_d_en  out  1  one-cycle write strobes; a_sel  out  1  0=load A from cu_instr, 1=from alu_result.
REQ-006 Status SHALL be: pc_q  out  16; halt  in  1  stop at next instruction boundary; retire  out  1  one-cycle pulse per completed instruction; bus_err  out  1  sticky timeout flag.

Function
REQ-007 Instruction fields: bit15 type (0=A, 1=C); bit12 a-bit (1=operand M); bits5:3 dest {A,D,M}; bits2:0 jump {lt,eq,gt}.
REQ-008 States SHALL be IDLE, FETCH, DECODE, MREAD, EXEC, MWRITE, ERROR.
REQ-009 IDLE: entered on reset, exits to FETCH after one cycle.
REQ-010 FETCH: if halt=1, stay with imem_req=0; else imem_req=1 held until imem_ack, then latch imem_rdata into cu_instr, go DECODE.
REQ-011 Ack arriving the same cycle req is first asserted SHALL be accepted; acks while req=0 SHALL be ignored.
REQ-012 DECODE, A-instr: pulse reg_a_en with a_sel=0, pc_q<=pc_q+1, pulse retire, go FETCH.
REQ-013 DECODE, C-instr: a-bit=1 go MREAD, else EXEC; also latch reg_a_q into internal addr_q.
REQ-014 MREAD: dmem_req=1, dmem_we=0, dmem_addr=addr_q until dmem_ack; latch dmem_rdata into reg_m_q, go EXEC.
REQ-015 EXEC: pulse reg_a_en (dest[5], a_sel=1) and reg_d_en (dest[4]); latch alu_result into dmem_wdata; evaluate jump.
REQ-016 Jump: lt=alu_result[15], eq=(alu_result==0), gt=!lt&&!eq; taken=(j[2]&lt)|(j[1]&eq)|(j[0]&gt); target=addr_q (A before this instruction's A write).
REQ-017 EXEC with dest[3]=1 SHALL go MWRITE; otherwise update pc, pulse retire, go FETCH.
REQ-018 MWRITE: dmem_req=1, dmem_we=1, dmem_addr=addr_q, dmem_wdata held until dmem_ack; then update pc, pulse retire, go FETCH.
REQ-019 pc update: taken ? addr_q : pc_q+1, 16-bit wrap (16'hFFFF -> 16'h0000).
REQ-020 Latency with zero-wait memory: A-instr 2 cycles, C-instr 3, +1 for M read, +1 for M write.
REQ-021 Wait counter SHALL clear on entry to each req state; on reaching ACK_TIMEOUT without ack go ERROR.
REQ-022 ERROR: all req/strobes 0, bus_err=1, remain until reset.
REQ-023 halt SHALL NOT abort an instruction in progress; it only blocks a new fetch.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, pc_q=RESET_PC, cu_instr=0, reg_m_q=0, addr_q=0, dmem_wdata=0, all req/we/strobes/retire/bus_err=0, wait counter=0, including mid-transaction.

Structure
REQ-025 Shared package luna_cpu_pkg SHALL hold the state encoding, instruction field bit positions and dest/jump bit indices.
REQ-026 Jump evaluation SHALL be a combinational sub-module jump_cond (alu_result, jump bits -> taken).

Verification
REQ-027 RESET_PC=0, zero-wait mem, instr 16'h0003 -> reg_a_en pulse with a_sel=0, retire 2 cycles after FETCH, pc_q=1.
REQ-028 reg_a_q=2, instr 16'b1110_000010_110_000, alu_result=5 -> reg_a_en and reg_d_en pulse with a_sel=1, no dmem_req, pc_q+1.
REQ-029 reg_a_q=4, instr 16'b1111_000010_001_000, dmem_rdata=7 -> dmem read addr 4, reg_m_q=7, dmem write addr 4 data alu_result, retire after MWRITE ack.
REQ-030 reg_a_q=16'h0020, instr jump 3'b100, alu_result=-5 -> pc_q=16'h0020; alu_result=2 -> pc_q+1.
REQ-031 imem_ack withheld 255 cycles -> bus_err=1, imem_req=0, state ERROR until rst=0.
REQ-032 rst=0 asserted during MREAD wait -> dmem_req drops immediately; after release, first fetch at addr 16'h0000; halt=1 at FETCH -> no imem_req.
